laser_cover_scorer: RTL and testbench

//  Point store and coverage scorer that feeds the LASER two-circle optimiser.
//  - Captures the 40 (X,Y) target points of one frame.
//  - On request, scores one candidate centre: counts stored points with
//    (px-cx)^2 + (py-cy)^2 <= RADIUS_SQ and returns the covered-point mask.
//  - Can exclude points already covered by a committed first circle, so the

---
 rtl/laser_cover_scorer_pkg.sv | 17 +
 rtl/laser_cover_scorer_if.sv | 32 +++
 rtl/laser_cover_scorer_dist_cmp.sv | 25 ++
 rtl/laser_cover_scorer.sv | 160 ++++++++++++++++
 tb/tb_laser_cover_scorer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/laser_cover_scorer_pkg.sv
// Shared constants, point type and controller states for the coverage scorer.
package laser_pkg;

  localparam int NPTS      = 40;                 // points per frame
  localparam int RADIUS_SQ = 16;                 // inclusive squared radius
  localparam int GRID_W    = 4;                  // coordinate width
  localparam int CNT_W     = $clog2(NPTS + 1);   // holds 0..NPTS
  localparam int IDX_W     = $clog2(NPTS);       // point index

  typedef struct packed {
    logic [GRID_W-1:0] x;
    logic [GRID_W-1:0] y;
  } point_t;

  typedef enum logic [2:0] {IDLE, LOAD, READY, SCAN, RESP} state_t;

endpackage

// File: rtl/laser_cover_scorer_if.sv
// Load / query / result signals between the optimiser and the scorer.
interface laser_cover_scorer_if;
  import laser_pkg::*;

  logic                   frame_start;
  logic                   load_vld;
  logic [GRID_W-1:0]      X;
  logic [GRID_W-1:0]      Y;
  logic                   load_done;
  logic                   q_start;
  logic [GRID_W-1:0]      q_cx;
  logic [GRID_W-1:0]      q_cy;
  logic                   q_excl_en;
  logic                   commit;
  logic                   q_busy;
  logic                   q_valid;
  logic [CNT_W-1:0]       q_count;
  logic [NPTS-1:0]        q_mask;

  // Optimiser side drives requests and points.
  modport master (
    output frame_start, load_vld, X, Y, q_start, q_cx, q_cy, q_excl_en, commit,
    input  load_done, q_busy, q_valid, q_count, q_mask
  );

  // Scorer side.
  modport slave (
    input  frame_start, load_vld, X, Y, q_start, q_cx, q_cy, q_excl_en, commit,
    output load_done, q_busy, q_valid, q_count, q_mask
  );

endinterface

// File: rtl/laser_cover_scorer_dist_cmp.sv
// One scan lane: is point (px,py) within the radius of centre (cx,cy)?
module laser_dist_cmp
  import laser_pkg::*;
(
  input  logic [GRID_W-1:0] px,
  input  logic [GRID_W-1:0] py,
  input  logic [GRID_W-1:0] cx,
  input  logic [GRID_W-1:0] cy,
  output logic              hit
);

  logic [GRID_W-1:0] dx;
  logic [GRID_W-1:0] dy;
  logic [8:0]        d2;

  // Absolute differences never wrap; squares are widened before multiplying
  // so 15*15 + 15*15 = 450 is represented exactly.
  always_comb begin
    dx  = (px >= cx) ? (px - cx) : (cx - px);
    dy  = (py >= cy) ? (py - cy) : (cy - py);
    d2  = 9'(dx) * 9'(dx) + 9'(dy) * 9'(dy);
    hit = (d2 <= 9'(RADIUS_SQ));
  end

endmodule

// File: rtl/laser_cover_scorer.sv
// Point store plus LANES-wide coverage scan for one candidate circle centre.
module laser_cover_scorer
  import laser_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  laser_cover_scorer_if.slave  bus
);

  localparam int NSLICE  = NPTS / LANES;
  localparam int SLICE_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  point_t                slot_q [NPTS];
  point_t                slot_d [NPTS];
  point_t                ctr_q, ctr_d;
  logic                  excl_en_q, excl_en_d;
  logic [NPTS-1:0]       excl_q, excl_d;
  logic [SLICE_W-1:0]    k_q, k_d;
  logic [CNT_W-1:0]      acc_q, acc_d;
  logic [NPTS-1:0]       mask_acc_q, mask_acc_d;
  logic [CNT_W-1:0]      q_count_q, q_count_d;
  logic [NPTS-1:0]       q_mask_q, q_mask_d;
  logic                  q_valid_q, q_valid_d;

  logic [IDX_W-1:0]      lane_idx [LANES];
  logic [LANES-1:0]      raw_hit;
  logic [LANES-1:0]      hit;

  // Lanes: point index for this slice, distance test, exclusion gating.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    point_t pt;
    assign lane_idx[l] = IDX_W'(k_q) * IDX_W'(LANES) + IDX_W'(l);
    assign pt          = slot_q[lane_idx[l]];

    laser_dist_cmp u_cmp (
      .px  (pt.x),
      .py  (pt.y),
      .cx  (ctr_q.x),
      .cy  (ctr_q.y),
      .hit (raw_hit[l])
    );

    assign hit[l] = raw_hit[l] & ~(excl_en_q & excl_q[lane_idx[l]]);
  end

  // Next-state, load, query and scan datapath.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one
    // unassigned; otherwise a latch would be inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    slot_d     = slot_q;
    ctr_d      = ctr_q;
    excl_en_d  = excl_en_q;
    excl_d     = excl_q;
    k_d        = k_q;
    acc_d      = acc_q;
    mask_acc_d = mask_acc_q;
    q_count_d  = q_count_q;
    q_mask_d   = q_mask_q;
    q_valid_d  = 1'b0;

    if (bus.frame_start) begin
      // Overrides everything else, from any state; an active scan is dropped.
      state_d    = LOAD;
      cnt_d      = '0;
      excl_d     = '0;
      k_d        = '0;
      acc_d      = '0;
      mask_acc_d = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (bus.load_vld) begin
            slot_d[cnt_q] = '{x: bus.X, y: bus.Y};
            cnt_d         = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(NPTS - 1)) state_d = READY;
          end
        end
        READY: begin
          // commit lands at the same edge as q_start, so the scan that
          // follows already reads the new exclusion mask.
          if (bus.commit) excl_d = q_mask_q;
          if (bus.q_start) begin
            ctr_d      = '{x: bus.q_cx, y: bus.q_cy};
            excl_en_d  = bus.q_excl_en;
            k_d        = '0;
            acc_d      = '0;
            mask_acc_d = '0;
            state_d    = SCAN;
          end
        end
        SCAN: begin
          for (int l = 0; l < LANES; l++) begin
            acc_d = acc_d + CNT_W'(hit[l]);
            if (hit[l]) mask_acc_d[lane_idx[l]] = 1'b1;
          end
          if (k_q == SLICE_W'(NSLICE - 1)) state_d = RESP;
          else                             k_d     = k_q + 1'b1;
        end
        RESP: begin
          q_count_d = acc_q;
          q_mask_d  = mask_acc_q;
          q_valid_d = 1'b1;
          state_d   = READY;
        end
        default: ;
      endcase
    end
  end

  // Control and result registers, cleared by the asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before this edge.
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ctr_q      <= '0;
      excl_en_q  <= 1'b0;
      excl_q     <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      mask_acc_q <= '0;
      q_count_q  <= '0;
      q_mask_q   <= '0;
      q_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ctr_q      <= ctr_d;
      excl_en_q  <= excl_en_d;
      excl_q     <= excl_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      mask_acc_q <= mask_acc_d;
      q_count_q  <= q_count_d;
      q_mask_q   <= q_mask_d;
      q_valid_q  <= q_valid_d;
    end
  end

  // Point store.
  always_ff @(posedge CLK) begin
    // NOTE: the store has no reset; cnt_q returning to 0 makes its contents
    // unreachable until a full frame has been rewritten.
    slot_q <= slot_d;
  end

  assign bus.load_done = (cnt_q == CNT_W'(NPTS));
  assign bus.q_busy    = (state_q == SCAN) || (state_q == RESP);
  assign bus.q_valid   = q_valid_q;
  assign bus.q_count   = q_count_q;
  assign bus.q_mask    = q_mask_q;

endmodule

// File: tb/tb_laser_cover_scorer.sv
// Directed bench for laser_cover_scorer: load, score, exclusion, protocol, reset.
module tb_laser_cover_scorer;
  import laser_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  laser_cover_scorer_if bus();

  laser_cover_scorer dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  logic [3:0] px [NPTS];
  logic [3:0] py [NPTS];

  localparam logic [39:0] ALL_ONES = 40'hFF_FFFF_FFFF;

  int          lat;
  logic [5:0]  cnt;
  logic [39:0] mask;
  logic        busy1, busy_at_valid, valid_after;
  logic        any_busy, any_valid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a frame and loads px/py; checks load_done just before and after the last point.
  task automatic load_frame(input string tag);
    bus.frame_start = 1'b1;
    @(negedge CLK);
    bus.frame_start = 1'b0;
    for (int i = 0; i < NPTS; i++) begin
      bus.load_vld = 1'b1;
      bus.X = px[i];
      bus.Y = py[i];
      if (i == NPTS - 1) check({tag, " load_done before last"}, 64'(bus.load_done), 64'd0);
      @(negedge CLK);
    end
    bus.load_vld = 1'b0;
    check({tag, " load_done"}, 64'(bus.load_done), 64'd1);
  endtask

  // Issues one query from a negedge; optional ignored q_start poke mid-scan.
  task automatic query(input logic [3:0] cx, input logic [3:0] cy, input logic excl,
                       input logic cmt, input logic poke);
    bus.q_cx = cx; bus.q_cy = cy; bus.q_excl_en = excl; bus.commit = cmt;
    bus.q_start = 1'b1;
    @(negedge CLK);
    bus.q_start = 1'b0; bus.commit = 1'b0;
    lat   = 1;
    busy1 = bus.q_busy;
    while (!bus.q_valid && lat < 30) begin
      if (poke && lat == 3) begin
        bus.q_start = 1'b1; bus.q_cx = 4'd0; bus.q_cy = 4'd0; bus.q_excl_en = 1'b1;
      end else begin
        bus.q_start = 1'b0;
      end
      @(negedge CLK);
      lat++;
    end
    bus.q_start = 1'b0;
    if (!bus.q_valid) lat = 0;
    cnt           = bus.q_count;
    mask          = bus.q_mask;
    busy_at_valid = bus.q_busy;
    @(negedge CLK);
    valid_after = bus.q_valid;
  endtask

  initial begin
    bus.frame_start = 1'b0; bus.load_vld = 1'b0; bus.X = '0; bus.Y = '0;
    bus.q_start = 1'b0; bus.q_cx = '0; bus.q_cy = '0; bus.q_excl_en = 1'b0;
    bus.commit = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Reset state.
    check("rst q_valid",   64'(bus.q_valid),   64'd0);
    check("rst q_busy",    64'(bus.q_busy),    64'd0);
    check("rst load_done", 64'(bus.load_done), 64'd0);
    check("rst q_count",   64'(bus.q_count),   64'd0);
    check("rst q_mask",    64'(bus.q_mask),    64'd0);

    // Test 1: all points at (5,5), query (5,5).
    for (int i = 0; i < NPTS; i++) begin px[i] = 4'd5; py[i] = 4'd5; end
    load_frame("t1");
    query(4'd5, 4'd5, 1'b0, 1'b0, 1'b0);
    check("t1 latency",       64'(lat),           64'd12);
    check("t1 busy rises",    64'(busy1),         64'd1);
    check("t1 busy at valid", 64'(busy_at_valid), 64'd0);
    check("t1 valid pulse",   64'(valid_after),   64'd0);
    check("t1 count",         64'(cnt),           64'd40);
    check("t1 mask",          64'(mask),          64'(ALL_ONES));
    check("t1 count holds",   64'(bus.q_count),   64'd40);

    // Test 4: commit the all-ones mask, then query with/without exclusion.
    bus.commit = 1'b1;
    @(negedge CLK);
    bus.commit = 1'b0;
    query(4'd5, 4'd5, 1'b1, 1'b0, 1'b0);
    check("t4 excl count", 64'(cnt),  64'd0);
    check("t4 excl mask",  64'(mask), 64'd0);
    // Also test 5a: a q_start in mid-scan must neither restart nor redirect the scan.
    query(4'd5, 4'd5, 1'b0, 1'b0, 1'b1);
    check("t4/t5 latency",  64'(lat), 64'd12);
    check("t4 noexcl count", 64'(cnt), 64'd40);
    any_valid = 1'b0;
    repeat (15) begin @(negedge CLK); any_valid |= bus.q_valid; end
    check("t5 no extra q_valid", 64'(any_valid), 64'd0);

    // Test 2: inclusive boundary, d2=16 accepted, d2=17 rejected.
    for (int i = 0; i < NPTS; i++) begin px[i] = 4'd15; py[i] = 4'd15; end
    px[0] = 4'd9; py[0] = 4'd5;
    px[1] = 4'd9; py[1] = 4'd6;
    load_frame("t2");
    query(4'd5, 4'd5, 1'b0, 1'b0, 1'b0);
    check("t2 count", 64'(cnt),  64'd1);
    check("t2 mask",  64'(mask), 64'd1);

    // Test 5b: load_vld in READY is ignored.
    bus.load_vld = 1'b1; bus.X = 4'd5; bus.Y = 4'd5;
    repeat (4) @(negedge CLK);
    bus.load_vld = 1'b0;
    check("t5 load_done kept", 64'(bus.load_done), 64'd1);
    query(4'd5, 4'd5, 1'b0, 1'b0, 1'b0);
    check("t5 ready load ignored", 64'(cnt), 64'd1);

    // Test 3: no wrap-around, (15,15) from (0,0) is d2=450.
    query(4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    check("t3 count", 64'(cnt),  64'd0);
    check("t3 mask",  64'(mask), 64'd0);
    query(4'd15, 4'd14, 1'b0, 1'b0, 1'b0);
    check("t3 near count", 64'(cnt),  64'd38);
    check("t3 near mask",  64'(mask), 64'(ALL_ONES & ~40'd3));

    // Test 5c: commit with q_start; query must see the new mask (bits 2..39).
    query(4'd15, 4'd15, 1'b1, 1'b1, 1'b0);
    check("t5 commit+start count", 64'(cnt),  64'd0);
    check("t5 commit+start mask",  64'(mask), 64'd0);
    query(4'd15, 4'd14, 1'b0, 1'b0, 1'b0);
    check("t5 refill count", 64'(cnt), 64'd38);

    // Test 6: reset during the 5th SCAN cycle.
    bus.q_cx = 4'd15; bus.q_cy = 4'd14; bus.q_excl_en = 1'b0;
    bus.q_start = 1'b1;
    @(negedge CLK);
    bus.q_start = 1'b0;
    repeat (4) @(negedge CLK);
    check("t6 busy before rst", 64'(bus.q_busy), 64'd1);
    RST = 1'b1;
    @(negedge CLK);
    check("t6 q_busy",    64'(bus.q_busy),    64'd0);
    check("t6 q_valid",   64'(bus.q_valid),   64'd0);
    check("t6 q_count",   64'(bus.q_count),   64'd0);
    check("t6 q_mask",    64'(bus.q_mask),    64'd0);
    check("t6 load_done", 64'(bus.load_done), 64'd0);
    RST = 1'b0;
    @(negedge CLK);
    bus.q_start = 1'b1;
    @(negedge CLK);
    bus.q_start = 1'b0;
    any_busy = 1'b0; any_valid = 1'b0;
    repeat (20) begin
      any_busy  |= bus.q_busy;
      any_valid |= bus.q_valid;
      @(negedge CLK);
    end
    check("t6 idle q_start busy",  64'(any_busy),  64'd0);
    check("t6 idle q_start valid", 64'(any_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
